lane_hit_judge: RTL and testbench
=================================

Name: lane_hit_judge

Overview:
- Multi-lane, parametrised hit judge for the rhythm game.
- Detects rising edges on per-lane buttons and grades each hit against the note offset from the shift logic into early, perfect or late, using configurable windows.
- Also detects missed notes, issues a one-shot delete per note, and serialises judgements one per cycle to the score logic.
- Keeps a saturating combo counter and a max-combo counter.

Parameters:
N_LANES, 2, number of note lanes/buttons
OFF_W, 3, width of each lane's offset
EARLY_OFF, 1, offset graded early
PERF_LO, 2, lowest offset graded perfect
PERF_HI, 4, highest offset graded perfect
LATE_OFF, 5, offset graded late
MISS_OFF, 6, offset at which an unhit note is a miss; must be greater than LATE_OFF
COMBO_W, 8, combo counter width
(local) LANE_W = max(1, clog2(N_LANES))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
btn  in  N_LANES  button levels, already synchronised; bit i = lane i
note_valid  in  N_LANES  note present in the judge zone of lane i
note_offset  in  N_LANES*OFF_W  lane i offset at bits [i*OFF_W +: OFF_W]
delete_note  out  N_LANES  one-cycle pulse: remove the current note in lane i
judge_valid  out  1  one-cycle pulse: a judgement is presented
judge_lane  out  LANE_W  lane of the presented judgement
judge_grade  out  2  11 perfect, 10 late, 01 early, 00 miss
combo  out  COMBO_W  current consecutive-hit count
max_combo  out  COMBO_W  highest combo since reset
overflow  out  1  sticky: a lane event was dropped

Behaviour:
- Reset: when rst=0 at a clk edge, all outputs, btn_prev, judged flags and pending flags go to 0.
- Edge detection: press[i] = btn[i] & ~btn_prev[i]; btn_prev is registered every cycle. A held button causes no further presses.
- Event generation in cycle t, per lane i, only when note_valid[i]=1 and judged[i]=0:
  - If press[i]=1 and offset is in EARLY_OFF, PERF_LO..PERF_HI or LATE_OFF: hit event with the matching grade.
  - If press[i]=1 and offset is outside all windows: press is ignored; no event and no state change.
  - If offset == MISS_OFF (press or not): miss event, grade 00.
  - Per-lane priority: miss outranks a press in the same cycle. This only matters if windows are misconfigured.
  - Press with note_valid[i]=0 is ignored.
- On any event in lane i at cycle t:
  - delete_note[i]=1 at t+1, for exactly one cycle.
  - judged[i] is set at t+1.
  - judged[i] clears on the first cycle note_valid[i]=0. It blocks double-judging while upstream removes the note.
- Pending buffer:
  - Each lane has one pending slot: a flag plus a 2-bit grade. The event is written at t+1.
  - If the slot is still full (not yet presented), the new event is dropped and overflow sets. delete_note and judged behave as normal.
- Output serialiser:
  - Each cycle, the lowest-indexed pending lane is presented as registered outputs judge_valid=1, judge_lane, judge_grade, and its slot is freed.
  - Minimum latency press → judge_valid is 2 cycles (t+2).
  - With no pending slot, judge_valid=0; judge_lane and judge_grade hold their last values.
  - A slot freed in a cycle may be refilled in the same cycle.
- Combo, updated on each presented judgement:
  - Grades 11/10/01: combo increments, saturating at 2^COMBO_W-1.
  - Grade 00: combo resets to 0.
  - max_combo updates in the same cycle to the new combo if it exceeds max_combo.
- Mid-operation reset: everything clears in the same edge. The next press is judged normally.

Test Plan:
- Lane 0, note_valid=1, offset=3, btn0 rises at t → delete_note=01 at t+1; judge_valid at t+2 with lane 0, grade 11; combo=1.
- Lane 1 offset=1 press → grade 01. Repeat with offset=5 → grade 10. Offset=7 press → no delete, no judge.
- Lane 0 at offset 6, no press → one miss (grade 00), combo 0; held note_valid afterwards produces no second event until it drops.
- Both lanes pressed the same cycle at offset 2 → lane 0 judged at t+2, lane 1 at t+3, both 11; delete_note=11 at t+1.
- Button held high for 10 cycles across offsets 2..4 → exactly one hit; release and re-press on the same note → ignored (judged).
- 260 consecutive perfects with COMBO_W=8 → combo saturates at 255, max_combo=255; next miss → combo 0, max_combo stays 255.
- Pulse rst low mid-run → all outputs 0 next edge.

Source files
------------

// File: rtl/lane_hit_judge.sv
// Multi-lane hit judge: grades button presses against note offsets, flags misses,
// queues one judgement per lane and presents them one per cycle with combo tracking.
module lane_hit_judge #(
  parameter int N_LANES   = 2,
  parameter int OFF_W     = 3,
  parameter int EARLY_OFF = 1,
  parameter int PERF_LO   = 2,
  parameter int PERF_HI   = 4,
  parameter int LATE_OFF  = 5,
  parameter int MISS_OFF  = 6,
  parameter int COMBO_W   = 8,
  localparam int LANE_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_LANES-1:0]       btn_i,
  input  logic [N_LANES-1:0]       note_valid_i,
  input  logic [N_LANES*OFF_W-1:0] note_offset_i,
  output logic [N_LANES-1:0]       delete_note_o,
  output logic                     judge_valid_o,
  output logic [LANE_W-1:0]        judge_lane_o,
  output logic [1:0]               judge_grade_o,
  output logic [COMBO_W-1:0]       combo_o,
  output logic [COMBO_W-1:0]       max_combo_o,
  output logic                     overflow_o
);

  localparam logic [OFF_W-1:0] EARLY_V   = OFF_W'(EARLY_OFF);
  localparam logic [OFF_W-1:0] PERF_LO_V = OFF_W'(PERF_LO);
  localparam logic [OFF_W-1:0] PERF_HI_V = OFF_W'(PERF_HI);
  localparam logic [OFF_W-1:0] LATE_V    = OFF_W'(LATE_OFF);
  localparam logic [OFF_W-1:0] MISS_V    = OFF_W'(MISS_OFF);

  localparam logic [1:0] GRADE_MISS  = 2'b00;
  localparam logic [1:0] GRADE_EARLY = 2'b01;
  localparam logic [1:0] GRADE_LATE  = 2'b10;
  localparam logic [1:0] GRADE_PERF  = 2'b11;

  logic [N_LANES-1:0]            btnPrev_q;
  logic [N_LANES-1:0]            judged_q, judged_d;
  logic [N_LANES-1:0]            pendValid_q, pendValid_d;
  logic [N_LANES-1:0][1:0]       pendGrade_q, pendGrade_d;
  logic [N_LANES-1:0]            delete_q;
  logic                          judgeValid_q;
  logic [LANE_W-1:0]             judgeLane_q;
  logic [1:0]                    judgeGrade_q;
  logic [COMBO_W-1:0]            combo_q, combo_d;
  logic [COMBO_W-1:0]            maxCombo_q, maxCombo_d;
  logic                          overflow_q;

  logic [N_LANES-1:0]            press;
  logic [N_LANES-1:0][OFF_W-1:0] laneOff;
  logic [N_LANES-1:0]            evt;
  logic [N_LANES-1:0][1:0]       evtGrade;
  logic                          selFound;
  logic [LANE_W-1:0]             selLane;
  logic [1:0]                    selGrade;
  logic                          ovfSet;

  assign press   = btn_i & ~btnPrev_q;
  assign laneOff = note_offset_i;

  // Miss is checked first so it wins over a press if the windows overlap it.
  always_comb begin
    evt      = '0;
    evtGrade = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (note_valid_i[i] && !judged_q[i]) begin
        if (laneOff[i] == MISS_V) begin
          evt[i]      = 1'b1;
          evtGrade[i] = GRADE_MISS;
        end else if (press[i]) begin
          if (laneOff[i] == EARLY_V) begin
            evt[i]      = 1'b1;
            evtGrade[i] = GRADE_EARLY;
          end else if (laneOff[i] >= PERF_LO_V && laneOff[i] <= PERF_HI_V) begin
            evt[i]      = 1'b1;
            evtGrade[i] = GRADE_PERF;
          end else if (laneOff[i] == LATE_V) begin
            evt[i]      = 1'b1;
            evtGrade[i] = GRADE_LATE;
          end
        end
      end
    end
  end

  // Lowest-indexed pending lane is presented; scanning downward leaves the lowest.
  always_comb begin
    selFound = 1'b0;
    selLane  = '0;
    selGrade = GRADE_MISS;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (pendValid_q[i]) begin
        selFound = 1'b1;
        selLane  = LANE_W'(i);
        selGrade = pendGrade_q[i];
      end
    end
  end

  // The slot is freed before new events are written, so it can refill the same cycle.
  always_comb begin
    pendValid_d = pendValid_q;
    pendGrade_d = pendGrade_q;
    ovfSet      = 1'b0;
    judged_d    = judged_q;
    if (selFound) begin
      pendValid_d[selLane] = 1'b0;
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (evt[i]) begin
        judged_d[i] = 1'b1;
        if (pendValid_d[i]) begin
          ovfSet = 1'b1;
        end else begin
          pendValid_d[i] = 1'b1;
          pendGrade_d[i] = evtGrade[i];
        end
      end else if (!note_valid_i[i]) begin
        judged_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    combo_d = combo_q;
    if (selFound) begin
      if (selGrade == GRADE_MISS) begin
        combo_d = '0;
      end else if (combo_q != {COMBO_W{1'b1}}) begin
        combo_d = combo_q + COMBO_W'(1);
      end
    end
    maxCombo_d = (combo_d > maxCombo_q) ? combo_d : maxCombo_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      btnPrev_q    <= '0;
      judged_q     <= '0;
      pendValid_q  <= '0;
      pendGrade_q  <= '0;
      delete_q     <= '0;
      judgeValid_q <= 1'b0;
      judgeLane_q  <= '0;
      judgeGrade_q <= '0;
      combo_q      <= '0;
      maxCombo_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      btnPrev_q    <= btn_i;
      judged_q     <= judged_d;
      pendValid_q  <= pendValid_d;
      pendGrade_q  <= pendGrade_d;
      delete_q     <= evt;
      judgeValid_q <= selFound;
      if (selFound) begin
        judgeLane_q  <= selLane;
        judgeGrade_q <= selGrade;
      end
      combo_q      <= combo_d;
      maxCombo_q   <= maxCombo_d;
      overflow_q   <= overflow_q | ovfSet;
    end
  end

  assign delete_note_o = delete_q;
  assign judge_valid_o = judgeValid_q;
  assign judge_lane_o  = judgeLane_q;
  assign judge_grade_o = judgeGrade_q;
  assign combo_o       = combo_q;
  assign max_combo_o   = maxCombo_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Directed bench for lane_hit_judge: a vector table for single-cycle behaviour plus
// hand sequences for held buttons, combo saturation, 4-lane overflow and mid-run reset.
module tb_lane_hit_judge;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  btn, noteValid, deleteNote;
  logic [5:0]  noteOffset;
  logic        judgeValid, judgeLane, overflow;
  logic [1:0]  judgeGrade;
  logic [7:0]  combo, maxCombo;

  logic [3:0]  btn4, noteValid4, deleteNote4;
  logic [11:0] noteOffset4;
  logic        judgeValid4, overflow4;
  logic [1:0]  judgeLane4, judgeGrade4;
  logic [7:0]  combo4, maxCombo4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lane_hit_judge dut (
    .clk_i(clk), .rst_ni(rstN), .btn_i(btn), .note_valid_i(noteValid),
    .note_offset_i(noteOffset), .delete_note_o(deleteNote), .judge_valid_o(judgeValid),
    .judge_lane_o(judgeLane), .judge_grade_o(judgeGrade), .combo_o(combo),
    .max_combo_o(maxCombo), .overflow_o(overflow)
  );

  lane_hit_judge #(.N_LANES(4)) dut4 (
    .clk_i(clk), .rst_ni(rstN), .btn_i(btn4), .note_valid_i(noteValid4),
    .note_offset_i(noteOffset4), .delete_note_o(deleteNote4), .judge_valid_o(judgeValid4),
    .judge_lane_o(judgeLane4), .judge_grade_o(judgeGrade4), .combo_o(combo4),
    .max_combo_o(maxCombo4), .overflow_o(overflow4)
  );

  typedef struct {
    logic [1:0] btn;
    logic [1:0] nv;
    logic [2:0] off0;
    logic [2:0] off1;
    logic [1:0] expDel;
    logic       expJv;
    logic       expLane;
    logic [1:0] expGrade;
    int         expCombo;
    int         expMax;
  } vec_t;

  vec_t vecs [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] b, input logic [1:0] nv,
                               input logic [2:0] o0, input logic [2:0] o1);
    btn        = b;
    noteValid  = nv;
    noteOffset = {o1, o0};
    step();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  int delCount, jvCount, lastGrade;

  initial begin
    rstN = 1'b0;
    btn = '0; noteValid = '0; noteOffset = '0;
    btn4 = '0; noteValid4 = '0; noteOffset4 = '0;
    step();
    step();
    checkOutput("reset delete", int'(deleteNote), 0);
    checkOutput("reset judge_valid", int'(judgeValid), 0);
    checkOutput("reset combo", int'(combo), 0);
    checkOutput("reset max_combo", int'(maxCombo), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    rstN = 1'b1;

    //          btn    nv     o0 o1  del    jv    ln    grade  cmb mx
    vecs[0]  = '{2'b00, 2'b01, 3, 0, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0};
    vecs[1]  = '{2'b01, 2'b01, 3, 0, 2'b01, 1'b0, 1'b0, 2'b00, 0, 0};
    vecs[2]  = '{2'b01, 2'b01, 4, 0, 2'b00, 1'b1, 1'b0, 2'b11, 1, 1};
    vecs[3]  = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1, 1};
    vecs[4]  = '{2'b10, 2'b10, 0, 1, 2'b10, 1'b0, 1'b0, 2'b00, 1, 1};
    vecs[5]  = '{2'b10, 2'b00, 0, 1, 2'b00, 1'b1, 1'b1, 2'b01, 2, 2};
    vecs[6]  = '{2'b00, 2'b10, 0, 5, 2'b00, 1'b0, 1'b0, 2'b00, 2, 2};
    vecs[7]  = '{2'b10, 2'b10, 0, 5, 2'b10, 1'b0, 1'b0, 2'b00, 2, 2};
    vecs[8]  = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 1'b1, 2'b10, 3, 3};
    vecs[9]  = '{2'b10, 2'b10, 0, 7, 2'b00, 1'b0, 1'b0, 2'b00, 3, 3};
    vecs[10] = '{2'b00, 2'b10, 0, 7, 2'b00, 1'b0, 1'b0, 2'b00, 3, 3};
    vecs[11] = '{2'b00, 2'b10, 0, 2, 2'b00, 1'b0, 1'b0, 2'b00, 3, 3};
    vecs[12] = '{2'b10, 2'b10, 0, 2, 2'b10, 1'b0, 1'b0, 2'b00, 3, 3};
    vecs[13] = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 1'b1, 2'b11, 4, 4};
    vecs[14] = '{2'b00, 2'b01, 6, 0, 2'b01, 1'b0, 1'b0, 2'b00, 4, 4};
    vecs[15] = '{2'b00, 2'b01, 6, 0, 2'b00, 1'b1, 1'b0, 2'b00, 0, 4};
    vecs[16] = '{2'b00, 2'b01, 6, 0, 2'b00, 1'b0, 1'b0, 2'b00, 0, 4};
    vecs[17] = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 0, 4};
    vecs[18] = '{2'b11, 2'b11, 2, 2, 2'b11, 1'b0, 1'b0, 2'b00, 0, 4};
    vecs[19] = '{2'b11, 2'b11, 2, 2, 2'b00, 1'b1, 1'b0, 2'b11, 1, 4};
    vecs[20] = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 1'b1, 2'b11, 2, 4};
    vecs[21] = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 2, 4};

    for (int v = 0; v < 22; v++) begin
      applyStimulus(vecs[v].btn, vecs[v].nv, vecs[v].off0, vecs[v].off1);
      checkOutput($sformatf("vec%0d delete", v), int'(deleteNote), int'(vecs[v].expDel));
      checkOutput($sformatf("vec%0d judge_valid", v), int'(judgeValid), int'(vecs[v].expJv));
      if (vecs[v].expJv) begin
        checkOutput($sformatf("vec%0d judge_lane", v), int'(judgeLane), int'(vecs[v].expLane));
        checkOutput($sformatf("vec%0d judge_grade", v), int'(judgeGrade), int'(vecs[v].expGrade));
      end
      checkOutput($sformatf("vec%0d combo", v), int'(combo), vecs[v].expCombo);
      checkOutput($sformatf("vec%0d max_combo", v), int'(maxCombo), vecs[v].expMax);
      checkOutput($sformatf("vec%0d overflow", v), int'(overflow), 0);
    end

    // Held button across the perfect window, then release and re-press the same note.
    delCount = 0; jvCount = 0; lastGrade = -1;
    for (int k = 0; k < 14; k++) begin
      if (k < 10)       applyStimulus(2'b01, 2'b01, 3'(2 + (k * 3) / 10), 0);
      else if (k == 10) applyStimulus(2'b00, 2'b01, 4, 0);
      else              applyStimulus(2'b01, 2'b01, 4, 0);
      if (deleteNote[0]) delCount++;
      if (judgeValid) begin
        jvCount++;
        lastGrade = int'(judgeGrade);
      end
    end
    checkOutput("held delete count", delCount, 1);
    checkOutput("held judge count", jvCount, 1);
    checkOutput("held grade", lastGrade, 3);
    checkOutput("held combo", int'(combo), 3);
    applyStimulus(2'b00, 2'b00, 0, 0);

    for (int k = 0; k < 260; k++) begin
      applyStimulus(2'b01, 2'b01, 3, 0);
      applyStimulus(2'b00, 2'b00, 0, 0);
    end
    applyStimulus(2'b00, 2'b00, 0, 0);
    checkOutput("saturated combo", int'(combo), 255);
    checkOutput("saturated max_combo", int'(maxCombo), 255);
    applyStimulus(2'b00, 2'b01, 6, 0);
    applyStimulus(2'b00, 2'b00, 0, 0);
    checkOutput("post-miss grade", int'(judgeGrade), 0);
    checkOutput("post-miss combo", int'(combo), 0);
    checkOutput("post-miss max_combo", int'(maxCombo), 255);

    // Four lanes hit together; lane 3 re-hits while its slot still waits -> overflow.
    noteOffset4 = {3'd3, 3'd3, 3'd3, 3'd3};
    btn4 = 4'b1111; noteValid4 = 4'b1111;
    step();
    checkOutput("x4 delete all", int'(deleteNote4), 15);
    checkOutput("x4 overflow clear", int'(overflow4), 0);
    btn4 = 4'b0000; noteValid4 = 4'b0000;
    step();
    checkOutput("x4 first lane", int'(judgeLane4), 0);
    btn4 = 4'b1000; noteValid4 = 4'b1000;
    step();
    checkOutput("x4 re-hit delete", int'(deleteNote4), 8);
    checkOutput("x4 overflow set", int'(overflow4), 1);
    checkOutput("x4 second lane", int'(judgeLane4), 1);
    btn4 = 4'b0000; noteValid4 = 4'b0000;
    step();
    checkOutput("x4 third lane", int'(judgeLane4), 2);
    step();
    checkOutput("x4 fourth lane", int'(judgeLane4), 3);
    checkOutput("x4 fourth valid", int'(judgeValid4), 1);
    step();
    checkOutput("x4 dropped event absent", int'(judgeValid4), 0);
    checkOutput("x4 combo", int'(combo4), 4);
    checkOutput("x4 overflow sticky", int'(overflow4), 1);

    // Reset arriving while a judgement is pending.
    applyStimulus(2'b01, 2'b01, 3, 0);
    checkOutput("pre-reset delete", int'(deleteNote), 1);
    rstN = 1'b0;
    applyStimulus(2'b00, 2'b00, 0, 0);
    checkOutput("mid reset delete", int'(deleteNote), 0);
    checkOutput("mid reset judge_valid", int'(judgeValid), 0);
    checkOutput("mid reset judge_lane", int'(judgeLane), 0);
    checkOutput("mid reset judge_grade", int'(judgeGrade), 0);
    checkOutput("mid reset max_combo", int'(maxCombo), 0);
    checkOutput("mid reset x4 overflow", int'(overflow4), 0);
    checkOutput("mid reset x4 combo", int'(combo4), 0);
    rstN = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0);
    checkOutput("no stale judge after reset", int'(judgeValid), 0);
    applyStimulus(2'b01, 2'b01, 2, 0);
    checkOutput("post-reset delete", int'(deleteNote), 1);
    applyStimulus(2'b00, 2'b00, 0, 0);
    checkOutput("post-reset judge_valid", int'(judgeValid), 1);
    checkOutput("post-reset grade", int'(judgeGrade), 3);
    checkOutput("post-reset combo", int'(combo), 1);
    checkOutput("post-reset max_combo", int'(maxCombo), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
